// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, RESP, BACKOFF} arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_RETRY_DEF  = 3;
  localparam int RETRY_W        = 4;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational rotate-priority picker, search starts at rr_ptr+1
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  int          pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IW'(pos);
      if (!valid && req[pos_idx]) begin
        valid = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin owner of the sync FIFO write port with overflow retry
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            drop,
  output logic                          busy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [DATA_WIDTH-1:0]   slice [NUM_REQ];
  logic                    resp_ok;
  logic                    at_limit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  fifo_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // A RESP with no ack counts as a failed attempt even when overflow is also low.
  always_comb begin
    resp_ok = 1'b0;
    casez ({fifo_wr_ack, fifo_overflow})
      2'b1?:   resp_ok = 1'b1;
      default: resp_ok = 1'b0;
    endcase
  end

  assign at_limit = (retry_q == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      data_q   <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    retry_d  = retry_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          idx_d   = pick_idx;
          data_d  = slice[pick_idx];
          state_d = WRITE;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ok || at_limit) begin
          rr_ptr_d = idx_q;
          retry_d  = '0;
          state_d  = IDLE;
        end else begin
          retry_d  = retry_q + 1'b1;
          state_d  = BACKOFF;
        end
      end
      BACKOFF: begin
        // Same idx and data are reused; no re-arbitration while retrying.
        if (!fifo_full) state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt          = '0;
    drop         = '0;
    busy         = (state_q != IDLE);
    fifo_wr_en   = (state_q == WRITE);
    fifo_data_in = data_q;
    if (state_q == RESP) begin
      if (resp_ok)       gnt[idx_q]  = 1'b1;
      else if (at_limit) drop[idx_q] = 1'b1;
    end
  end

endmodule
